execute_mc: RTL and testbench

EXECUTE_MC -- requirements
Module: execute_mc

---
 rtl/execute_mc_pkg.sv | 32 +++
 rtl/execute_mc_mult_iter.sv | 55 +++++
 rtl/execute_mc.sv | 184 ++++++++++++++++++
 tb/tb_execute_mc.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/execute_mc_pkg.sv
// Shared definitions for the execute_mc slice: operation codes and the
// multiplier control FSM states.
package exec_mc_defs;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_XOR  = 4'd3,
    OP_ROL  = 4'd4,
    OP_ROR  = 4'd5,
    OP_SLL  = 4'd6,
    OP_SRL  = 4'd7,
    OP_SEQ  = 4'd8,
    OP_SLT  = 4'd9,
    OP_SLE  = 4'd10,
    OP_SCO  = 4'd11,
    OP_BTR  = 4'd12,
    OP_SLBI = 4'd13,
    OP_MUL  = 4'd14,
    OP_ILL  = 4'd15
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned SLBI_SHIFT = 8;

endpackage

// File: rtl/execute_mc_mult_iter.sv
// Iterative shift-add multiplier producing the low WIDTH bits of a*b.
// One partial product per cycle; done_o is high during the final iteration.
module mult_iter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic             running_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_d;

  // product_o is the accumulator after the current step, so the parent can
  // capture the full product on the same edge that completes the last step.
  assign acc_d     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign done_o    = running_q && (cnt_q == LAST);
  assign product_o = acc_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      running_q <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
    end else if (start_i) begin
      running_q <= 1'b1;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= a_i;
      mplier_q  <= b_i;
    end else if (running_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        running_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/execute_mc.sv
// Execute unit: single-cycle ALU plus optional iterative multiply with a
// valid/ready handshake on both sides. MUL is built only with EXECUTE_MC_MUL_EN.
module execute_mc
  import exec_mc_defs::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] branch_tgt,
  output logic             zero,
  output logic             ltz,
  output logic             ofl,
  output logic             err,
  output logic             busy
);

  logic             accept;
  logic             mulOp;
  logic [WIDTH-1:0] aluRes;
  logic             aluOfl;
  logic             aluErr;
  logic [WIDTH:0]   addFull;
  logic [WIDTH-1:0] subRes;
  logic [SHW-1:0]   amt;
  logic [SHW:0]     amtInv;
  logic [WIDTH-1:0] tgt;

  logic             outValid_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] branch_q;
  logic             zero_q;
  logic             ltz_q;
  logic             ofl_q;
  logic             err_q;

`ifdef EXECUTE_MC_MUL_EN
  state_e           state_q;
  logic             multDone;
  logic [WIDTH-1:0] multProd;

  assign mulOp = (op_e'(op) == OP_MUL);
  assign busy  = (state_q != ST_IDLE);

  mult_iter #(
    .WIDTH(WIDTH)
  ) u_mult (
    .clk      (clk),
    .rst      (rst),
    .start_i  (accept && mulOp),
    .a_i      (a),
    .b_i      (b),
    .done_o   (multDone),
    .product_o(multProd)
  );
`else
  assign mulOp = 1'b0;
  assign busy  = 1'b0;
`endif

  assign in_ready   = ~busy & (~outValid_q | out_ready);
  assign accept     = in_valid & in_ready;
  assign tgt        = pc + imm;
  assign out_valid  = outValid_q;
  assign result     = result_q;
  assign branch_tgt = branch_q;
  assign zero       = zero_q;
  assign ltz        = ltz_q;
  assign ofl        = ofl_q;
  assign err        = err_q;

  // Rotates are built from two opposing shifts; a zero amount makes the
  // complementary shift equal WIDTH, which contributes nothing.
  always_comb begin
    amt     = b[SHW-1:0];
    amtInv  = (SHW+1)'(WIDTH) - {1'b0, amt};
    addFull = {1'b0, a} + {1'b0, b};
    subRes  = a - b;
    aluRes  = '0;
    aluOfl  = 1'b0;
    aluErr  = 1'b0;
    case (op_e'(op))
      OP_ADD: begin
        aluRes = addFull[WIDTH-1:0];
        aluOfl = (a[WIDTH-1] == b[WIDTH-1]) && (addFull[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        aluRes = subRes;
        aluOfl = (a[WIDTH-1] != b[WIDTH-1]) && (subRes[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  aluRes = a & b;
      OP_XOR:  aluRes = a ^ b;
      OP_ROL:  aluRes = (a << amt) | (a >> amtInv);
      OP_ROR:  aluRes = (a >> amt) | (a << amtInv);
      OP_SLL:  aluRes = a << amt;
      OP_SRL:  aluRes = a >> amt;
      OP_SEQ:  aluRes[0] = (a == b);
      OP_SLT:  aluRes[0] = ($signed(a) < $signed(b));
      OP_SLE:  aluRes[0] = ($signed(a) <= $signed(b));
      OP_SCO:  aluRes[0] = addFull[WIDTH];
      OP_BTR: begin
        for (int i = 0; i < WIDTH; i++) begin
          aluRes[i] = a[WIDTH-1-i];
        end
      end
      OP_SLBI: begin
        aluRes      = a << SLBI_SHIFT;
        aluRes[7:0] = b[7:0];
      end
      default: aluErr = 1'b1;
    endcase
  end

  // Output registers and, when built, the IDLE/MUL/DONE sequencer. A MUL
  // accepted in IDLE drops out_valid until the multiplier finishes.
  always_ff @(posedge clk) begin
    if (rst) begin
      outValid_q <= 1'b0;
      result_q   <= '0;
      branch_q   <= '0;
      zero_q     <= 1'b0;
      ltz_q      <= 1'b0;
      ofl_q      <= 1'b0;
      err_q      <= 1'b0;
`ifdef EXECUTE_MC_MUL_EN
      state_q    <= ST_IDLE;
`endif
    end else begin
      if (accept) begin
        branch_q <= tgt;
        if (mulOp) begin
          outValid_q <= 1'b0;
        end else begin
          outValid_q <= 1'b1;
          result_q   <= aluRes;
          zero_q     <= ~aluErr & (aluRes == '0);
          ltz_q      <= ~aluErr & aluRes[WIDTH-1];
          ofl_q      <= aluOfl;
          err_q      <= aluErr;
        end
      end else if (outValid_q && out_ready) begin
        outValid_q <= 1'b0;
      end
`ifdef EXECUTE_MC_MUL_EN
      case (state_q)
        ST_IDLE: begin
          if (accept && mulOp) begin
            state_q <= ST_MUL;
          end
        end
        ST_MUL: begin
          if (multDone) begin
            state_q    <= ST_DONE;
            outValid_q <= 1'b1;
            result_q   <= multProd;
            zero_q     <= (multProd == '0);
            ltz_q      <= multProd[WIDTH-1];
            ofl_q      <= 1'b0;
            err_q      <= 1'b0;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
`endif
    end
  end

endmodule

// File: tb/tb_execute_mc.sv
// Self-checking bench for execute_mc: directed corner cases plus random
// traffic against a transaction-level model. Honours EXECUTE_MC_MUL_EN.
module tb_execute_mc;

  localparam int     W    = 16;
  localparam longint MOD  = 64'd1 << W;
  localparam longint HALF = MOD / 2;
`ifdef EXECUTE_MC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  localparam int C_ADD = 0, C_SUB = 1, C_AND = 2, C_XOR = 3, C_ROL = 4, C_ROR = 5;
  localparam int C_SLL = 6, C_SRL = 7, C_SEQ = 8, C_SLT = 9, C_SLE = 10, C_SCO = 11;
  localparam int C_BTR = 12, C_SLBI = 13, C_MUL = 14, C_ILL = 15;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [3:0]   op;
  logic [W-1:0] a, b, pc, imm, result, branch_tgt;
  logic         zero, ltz, ofl, err, busy;

  logic         in_valid32, in_ready32, out_valid32, out_ready32;
  logic [3:0]   op32;
  logic [31:0]  a32, b32, pc32, imm32, result32, tgt32;
  logic         zero32, ltz32, ofl32, err32, busy32;

  int checks = 0;
  int errors = 0;

  typedef struct {
    longint res;
    longint tgt;
    bit     zero;
    bit     ltz;
    bit     ofl;
    bit     err;
  } rec_t;

  bit   mPend;
  bit   mCurMul;
  int   mulLeft;
  rec_t mCur;
  rec_t mMulRec;

  always #5 clk = ~clk;

  execute_mc #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .pc(pc), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .branch_tgt(branch_tgt), .zero(zero), .ltz(ltz), .ofl(ofl),
    .err(err), .busy(busy)
  );

  execute_mc #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32), .op(op32),
    .a(a32), .b(b32), .pc(pc32), .imm(imm32), .out_valid(out_valid32),
    .out_ready(out_ready32), .result(result32), .branch_tgt(tgt32), .zero(zero32),
    .ltz(ltz32), .ofl(ofl32), .err(err32), .busy(busy32)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic longint sgn(input longint v);
    return (v >= HALF) ? v - MOD : v;
  endfunction

  function automatic rec_t refModel(input int opv, input longint av, input longint bv,
                                    input longint pcv, input longint immv);
    rec_t   r;
    longint amt;
    longint t;
    amt   = bv % W;
    r.res = 0;
    r.tgt = (pcv + immv) % MOD;
    r.ofl = 0;
    r.err = 0;
    case (opv)
      C_ADD: begin
        t     = sgn(av) + sgn(bv);
        r.res = (av + bv) % MOD;
        r.ofl = (t > HALF - 1) || (t < -HALF);
      end
      C_SUB: begin
        t     = sgn(av) - sgn(bv);
        r.res = (av - bv + MOD) % MOD;
        r.ofl = (t > HALF - 1) || (t < -HALF);
      end
      C_AND: r.res = av & bv;
      C_XOR: r.res = av ^ bv;
      C_ROL: begin
        r.res = av;
        repeat (amt) r.res = (r.res * 2) % MOD + r.res / HALF;
      end
      C_ROR: begin
        r.res = av;
        repeat (amt) r.res = r.res / 2 + (r.res % 2) * HALF;
      end
      C_SLL: r.res = (av * (64'd1 << amt)) % MOD;
      C_SRL: r.res = av / (64'd1 << amt);
      C_SEQ: r.res = (sgn(av) == sgn(bv)) ? 1 : 0;
      C_SLT: r.res = (sgn(av) <  sgn(bv)) ? 1 : 0;
      C_SLE: r.res = (sgn(av) <= sgn(bv)) ? 1 : 0;
      C_SCO: r.res = (av + bv >= MOD) ? 1 : 0;
      C_BTR: begin
        for (int i = 0; i < W; i++) begin
          if (((av >> i) % 2) == 1) r.res = r.res + (64'd1 << (W - 1 - i));
        end
      end
      C_SLBI: r.res = (av * 256) % MOD + bv % 256;
      C_MUL: begin
        if (MUL_EN) r.res = (av * bv) % MOD;
        else r.err = 1;
      end
      default: r.err = 1;
    endcase
    r.zero = !r.err && (r.res == 0);
    r.ltz  = !r.err && (r.res >= HALF);
    return r;
  endfunction

  // One clock of stimulus: drive, check the presented state, clock, advance model.
  task automatic applyStimulus(input bit rstV, input bit ivV, input int opV, input longint aV,
                               input longint bV, input longint pcV, input longint immV,
                               input bit ordyV);
    bit   expReady, acc, xfer, mBusy;
    rec_t nr;
    rst       = rstV;
    in_valid  = ivV;
    op        = opV[3:0];
    a         = aV[W-1:0];
    b         = bV[W-1:0];
    pc        = pcV[W-1:0];
    imm       = immV[W-1:0];
    out_ready = ordyV;
    #1;
    mBusy    = (mulLeft > 0) || (mPend && mCurMul);
    expReady = !mBusy && (!mPend || ordyV);
    if (!rstV) begin
      checkOutput("in_ready", in_ready, expReady);
      checkOutput("out_valid", out_valid, mPend);
      checkOutput("busy", busy, mBusy);
      if (mPend) begin
        checkOutput("result", result, mCur.res);
        checkOutput("branch_tgt", branch_tgt, mCur.tgt);
        checkOutput("flags", {zero, ltz, ofl, err}, {mCur.zero, mCur.ltz, mCur.ofl, mCur.err});
      end
    end
    acc  = ivV && expReady && !rstV;
    xfer = mPend && ordyV && !rstV;
    nr   = refModel(opV, aV % MOD, bV % MOD, pcV % MOD, immV % MOD);
    @(posedge clk);
    if (rstV) begin
      mPend = 0; mulLeft = 0; mCurMul = 0;
    end else if (mulLeft > 0) begin
      mulLeft--;
      if (mulLeft == 0) begin
        mPend = 1; mCur = mMulRec; mCurMul = 1;
      end
    end else if (acc) begin
      if (MUL_EN && opV == C_MUL) begin
        mulLeft = W; mPend = 0; mCurMul = 0; mMulRec = nr;
      end else begin
        mPend = 1; mCur = nr; mCurMul = 0;
      end
    end else if (xfer) begin
      mPend = 0; mCurMul = 0;
    end
    #1;
  endtask

  function automatic longint pickOperand();
    case ($urandom_range(0, 5))
      0:       return 0;
      1:       return 64'h7FFF;
      2:       return 64'h8000;
      3:       return 64'hFFFF;
      default: return longint'($urandom_range(0, 65535));
    endcase
  endfunction

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int     lat;
    int     sawValid;
    rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; pc = '0; imm = '0; out_ready = 1'b0;
    in_valid32 = 1'b0; op32 = '0; a32 = '0; b32 = '0; pc32 = '0; imm32 = '0; out_ready32 = 1'b0;
    mPend = 0; mCurMul = 0; mulLeft = 0;
    @(posedge clk); #1;

    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, C_ADD, 5, 5, 0, 0, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_result", result, 0);
    checkOutput("rst_branch", branch_tgt, 0);
    checkOutput("rst_flags", {zero, ltz, ofl, err, busy}, 5'b0);
    checkOutput("rst_in_ready", in_ready, 1);

    applyStimulus(0, 1, C_ADD, 'h7FFF, 'h0001, 'h0100, 'h0020, 1);
    checkOutput("add_ofl_result", result, 'h8000);
    checkOutput("add_ofl_flags", {ofl, ltz, err, zero}, 4'b1100);
    checkOutput("add_ofl_tgt", branch_tgt, 'h0120);

    applyStimulus(0, 1, C_ROR, 'h0001, 'h0011, 0, 0, 1);
    checkOutput("ror_mod_result", result, 'h8000);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, C_ADD, 3 * i + 1, i, 0, 0, 1);
      checkOutput("b2b_valid", out_valid, 1);
      checkOutput("b2b_result", result, 4 * i + 1);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, C_ADD, 9, 9, 0, 0, 0);
      checkOutput("stall_result", result, 13);
    end
    checkOutput("stall_ready", in_ready, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);

`ifdef EXECUTE_MC_MUL_EN
    applyStimulus(0, 1, C_MUL, 'h0123, 'h0010, 0, 0, 1);
    checkOutput("mul_busy", busy, 1);
    lat = 1;
    while (!out_valid && lat < 40) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      lat++;
    end
    checkOutput("mul_latency", lat, 17);
    checkOutput("mul_result", result, 'h1230);
    checkOutput("mul_done_busy", busy, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("mul_consumed", {out_valid, busy}, 2'b00);

    applyStimulus(0, 1, C_MUL, 'h0FFF, 'h0FFF, 0, 0, 1);
    repeat (5) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    #1;
    checkOutput("abort_ready", in_ready, 1);
    sawValid = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      if (out_valid) sawValid++;
    end
    checkOutput("abort_no_result", sawValid, 0);
`else
    applyStimulus(0, 1, C_MUL, 'h0123, 'h0010, 0, 0, 1);
    checkOutput("mul_ill_err", {out_valid, err, busy}, 3'b110);
    checkOutput("mul_ill_result", result, 0);
    applyStimulus(0, 1, C_ILL, 'h1234, 'h5678, 0, 0, 1);
    checkOutput("op15_err", {out_valid, err, zero, ltz, ofl}, 5'b11000);
    checkOutput("op15_result", result, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
`endif

    for (int n = 0; n < 600; n++) begin
      applyStimulus(($urandom_range(0, 59) == 0), ($urandom_range(0, 9) < 7),
                    int'($urandom_range(0, 15)), pickOperand(), pickOperand(),
                    pickOperand(), pickOperand(), ($urandom_range(0, 9) < 7));
    end

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    lat = 0;
    while ((busy || out_valid) && lat < 40) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
      lat++;
    end
    checkOutput("drain_idle", {busy, out_valid}, 2'b00);

    in_valid32 = 1'b1; op32 = 4'(C_SLT); a32 = 32'hFFFF_FFFF; b32 = 32'h0;
    pc32 = 32'hFFFF_FFFE; imm32 = 32'h4; out_ready32 = 1'b1;
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    checkOutput("w32_valid", out_valid32, 1);
    checkOutput("w32_slt", result32, 1);
    checkOutput("w32_tgt", tgt32, 32'h0000_0002);
    checkOutput("w32_err_ofl", {err32, ofl32}, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
